// File: rtl/tick_counter.sv
// tick_counter: up/down event counter stepped by an internal clock-enable prescaler.
// Build option: define TICK_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module tick_counter #(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             at_zero,
  output logic             at_max
);

  localparam int unsigned         Div      = CLK_HZ / TICK_HZ;
  localparam int unsigned         PreWidth = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PreWidth-1:0] PreLast  = PreWidth'(Div - 1);
  localparam logic [WIDTH-1:0]    CountMax = {WIDTH{1'b1}};

  if (Div < 2) begin : g_bad_div
    $error("tick_counter: CLK_HZ / TICK_HZ must be at least 2");
  end

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tick_counter: WIDTH must be in 1..32");
  end

  // Two-flop synchronisers for the asynchronous board pins, packed {clear, up_down, enable}.
  logic [2:0] sync_meta_q;
  logic [2:0] sync_q;
  logic       enable_s;
  logic       up_down_s;
  logic       clear_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= {clear, up_down, enable};
      sync_q      <= sync_meta_q;
    end
  end

  assign {clear_s, up_down_s, enable_s} = sync_q;

  // Prescaler: free-running 0..Div-1, only clear_s restarts it.
  logic [PreWidth-1:0] p_q;
  logic [PreWidth-1:0] p_d;
  logic                tick_q;
  logic                tick_d;

  always_comb begin
    p_d    = (p_q == PreLast) ? '0 : p_q + PreWidth'(1);
    tick_d = (p_q == PreLast);
    if (clear_s) begin
      p_d    = '0;
      tick_d = 1'b0;
    end
  end

  // Count datapath.
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_val;
  logic             step_edge;

  assign step_val  = up_down_s ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  // Set when the pending step would leave the representable range.
  assign step_edge = up_down_s ? (count_q == CountMax) : (count_q == '0);

`ifndef TICK_COUNTER_SATURATE_EN
  logic wrap_q;
  logic wrap_d;
`endif

  always_comb begin
    count_d = count_q;
`ifndef TICK_COUNTER_SATURATE_EN
    wrap_d  = 1'b0;
`endif
    if (clear_s) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (tick_q && enable_s) begin
`ifdef TICK_COUNTER_SATURATE_EN
      if (!step_edge) begin
        count_d = step_val;
      end
`else
      count_d = step_val;
      wrap_d  = step_edge;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q     <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
    end else begin
      p_q     <= p_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

`ifdef TICK_COUNTER_SATURATE_EN
  assign wrap = 1'b0;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

  assign count   = count_q;
  assign tick    = tick_q;
  assign at_zero = (count_q == '0);
  assign at_max  = (count_q == CountMax);

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter with CLK_HZ=8, TICK_HZ=1 (tick every 8 cycles), WIDTH=4.
module tb_tick_counter;

`ifdef TICK_COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count;
  logic       tick;
  logic       wrap;
  logic       at_zero;
  logic       at_max;

  tick_counter #(
    .CLK_HZ (8),
    .TICK_HZ(1),
    .WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .up_down   (up_down),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tick      (tick),
    .wrap      (wrap),
    .at_zero   (at_zero),
    .at_max    (at_max)
  );

  always #5 clk = ~clk;

  // Inputs held for n rising edges, then outputs compared on the following falling edge.
  typedef struct {
    logic       en;
    logic       ud;
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    int         n;
    logic [3:0] exp_count;
    logic       exp_tick;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   wrap_seen = 0;

  always @(negedge clk) if (wrap === 1'b1) wrap_seen++;

  task automatic add(input logic en, input logic ud, input logic clr, input logic ld,
                     input logic [3:0] lv, input int n, input logic [3:0] c, input logic t,
                     input logic w);
    vec_t v;
    v.en = en; v.ud = ud; v.clr = clr; v.ld = ld; v.lv = lv; v.n = n;
    v.exp_count = c; v.exp_tick = t; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  // Packed as {count, tick, wrap, at_zero, at_max}.
  task automatic check_outs(input string name, input logic [3:0] c, input logic t,
                            input logic w);
    logic [7:0] act;
    logic [7:0] exp;
    act = {count, tick, wrap, at_zero, at_max};
    exp = {c, t, w, (c == 4'd0), (c == 4'd15)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {count,tick,wrap,at_zero,at_max} got %b_%b%b%b%b expected %b_%b%b%b%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply_row(input int i);
    enable     = vecs[i].en;
    up_down    = vecs[i].ud;
    clear      = vecs[i].clr;
    load       = vecs[i].ld;
    load_value = vecs[i].lv;
    repeat (vecs[i].n) @(negedge clk);
    check_outs($sformatf("row%0d", i), vecs[i].exp_count, vecs[i].exp_tick, vecs[i].exp_wrap);
  endtask

  initial begin
    // Reset period and tick cadence, counting disabled (edge count t after release in notes).
    add(0, 0, 0, 0, 4'd0,   7, 4'd0,  0, 0);                     // t=7
    add(0, 0, 0, 0, 4'd0,   1, 4'd0,  1, 0);                     // t=8 first tick
    add(0, 0, 0, 0, 4'd0,   1, 4'd0,  0, 0);                     // t=9
    add(0, 0, 0, 0, 4'd0,   7, 4'd0,  1, 0);                     // t=16
    add(0, 0, 0, 0, 4'd0,   8, 4'd0,  1, 0);                     // t=24
    // Up count; enable_s not yet high at edge 25, so first step is edge 33.
    add(1, 1, 0, 0, 4'd0,   1, 4'd0,  0, 0);                     // t=25
    add(1, 1, 0, 0, 4'd0,   8, 4'd1,  0, 0);                     // t=33
    add(1, 1, 0, 0, 4'd0,   7, 4'd1,  1, 0);                     // t=40
    add(1, 1, 0, 0, 4'd0, 105, 4'd15, 0, 0);                     // t=145
    add(1, 1, 0, 0, 4'd0,   7, 4'd15, 1, 0);                     // t=152
    add(1, 1, 0, 0, 4'd0,   1, Sat ? 4'd15 : 4'd0, 0, !Sat);     // t=153 roll over
    add(1, 1, 0, 0, 4'd0,   1, Sat ? 4'd15 : 4'd0, 0, 0);        // t=154
    // Down count from 0 (non-saturating) or from 15 (saturating).
    add(1, 0, 0, 0, 4'd0,   7, Sat ? 4'd14 : 4'd15, 0, !Sat);    // t=161
    add(1, 0, 0, 0, 4'd0,   1, Sat ? 4'd14 : 4'd15, 0, 0);       // t=162
    add(1, 0, 0, 0, 4'd0,   7, Sat ? 4'd13 : 4'd14, 0, 0);       // t=169
    // Load off-tick, then load on a step edge suppressing the step.
    add(1, 0, 0, 1, 4'd9,   1, 4'd9,  0, 0);                     // t=170
    add(1, 0, 0, 0, 4'd9,   6, 4'd9,  1, 0);                     // t=176
    add(1, 0, 0, 1, 4'd9,   1, 4'd9,  0, 0);                     // t=177
    add(1, 0, 0, 0, 4'd9,   8, 4'd8,  0, 0);                     // t=185
    // Clear pin: clear_s wins over load at edge 188, prescaler restarts.
    add(1, 0, 1, 0, 4'd5,   2, 4'd8,  0, 0);                     // t=187
    add(1, 0, 0, 1, 4'd5,   1, 4'd0,  0, 0);                     // t=188
    add(1, 0, 0, 0, 4'd5,   1, 4'd0,  0, 0);                     // t=189
    add(1, 0, 0, 0, 4'd5,   7, 4'd0,  0, 0);                     // t=196
    add(1, 0, 0, 0, 4'd5,   1, 4'd0,  1, 0);                     // t=197
    add(1, 0, 0, 0, 4'd5,   1, Sat ? 4'd0 : 4'd15, 0, !Sat);     // t=198
    // Synchroniser latency on enable; step edges are 206, 214, 222, 230, 238.
    add(0, 1, 0, 1, 4'd3,   1, 4'd3,  0, 0);                     // t=199
    add(0, 1, 0, 0, 4'd3,   7, 4'd3,  0, 0);                     // t=206 disabled
    add(0, 1, 0, 0, 4'd3,   6, 4'd3,  0, 0);                     // t=212
    add(1, 1, 0, 0, 4'd3,   2, 4'd3,  0, 0);                     // t=214 2 edges: ignored
    add(1, 1, 0, 0, 4'd3,   8, 4'd4,  0, 0);                     // t=222
    add(0, 1, 0, 0, 4'd3,  13, 4'd4,  0, 0);                     // t=235
    add(1, 1, 0, 0, 4'd3,   3, 4'd5,  0, 0);                     // t=238 3 edges: steps
    // Park at 7 with a tick pending for the async reset test.
    add(1, 1, 0, 1, 4'd7,   1, 4'd7,  0, 0);                     // t=239
    add(1, 1, 0, 0, 4'd7,   6, 4'd7,  1, 0);                     // t=245

    repeat (2) @(negedge clk);
    check_outs("reset_state", 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) apply_row(i);
    #1;
    checks++;
    if (wrap_seen != (Sat ? 0 : 1)) begin
      failures++;
      $display("FAIL wrap_count_up: got %0d pulses expected %0d", wrap_seen, Sat ? 0 : 1);
    end
    for (int i = 12; i < vecs.size(); i++) apply_row(i);

    // Asynchronous reset mid-count, before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_outs("async_reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    check_outs("post_reset_t7", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("post_reset_t8", 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("post_reset_t9", 4'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised up/down event counter with an integrated clock-enable prescaler, synchronised board-level controls, synchronous load/clear and wrap signalling. Drives LED banks and general status displays directly from the 12 MHz board clock. No derived clocks: all state runs on `clk`, and the count advances only on prescaler ticks.

## Interface
- `CLK_HZ`, default 12000000: input clock frequency in Hz.
- `TICK_HZ`, default 1: count rate in Hz. `DIV = CLK_HZ / TICK_HZ`, integer division. `DIV >= 2` is required; elaboration fails otherwise.
- `WIDTH`, default 4: count width in bits, 1..32.
- `clk`, in, 1: system clock, rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: asynchronous pin; counting allowed while high.
- `up_down`, in, 1: asynchronous pin; 1 = count up, 0 = count down.
- `clear`, in, 1: asynchronous pin; synchronous clear of count and prescaler.
- `load`, in, 1: synchronous to `clk`; loads `load_value` on the next edge.
- `load_value`, in, WIDTH: value for load. Must be stable while `load` is high.
- `count`, out, WIDTH: current count, registered.
- `tick`, out, 1: registered one-cycle pulse every `DIV` cycles.
- `wrap`, out, 1: registered one-cycle pulse when count rolls over.
- `at_zero`, out, 1: `count == 0`, decoded from the registered count.
- `at_max`, out, 1: `count == 2^WIDTH-1`, decoded from the registered count.

## Operation
- Synchronisers:
  - `enable`, `up_down` and `clear` each pass through a 2-flop synchroniser, reset to 0.
  - Internal copies carry the suffix `_s`.
- Prescaler:
  - `p` has width `$clog2(DIV)`. It counts `0..DIV-1`, then returns to 0. It is free-running regardless of `enable_s`.
  - `tick <= (p == DIV-1)`.
- Count update priority, evaluated each edge:
  1. `clear_s`: `count <= 0`, `p <= 0`, `tick <= 0`, `wrap <= 0`.
  2. `load`: `count <= load_value`, `wrap <= 0`. The prescaler is unaffected.
  3. `tick && enable_s`: step the count by ±1 per `up_down_s`.
  4. Otherwise: hold the count, `wrap <= 0`.
- Stepping:
  - Up from `2^WIDTH-1` goes to 0, with `wrap <= 1`.
  - Down from 0 goes to `2^WIDTH-1`, with `wrap <= 1`.
  - All other steps give `wrap <= 0`.
- Arithmetic is modulo `2^WIDTH`. No overflow flag exists beyond `wrap`.
- Reset (`reset_n` low), effective immediately:
  - `count = 0`, `p = 0`, `tick = 0`, `wrap = 0`.
  - All synchroniser flops = 0.
  - `at_zero = 1`, `at_max = 0`.
- Reset asserted mid-count discards all state. After release, the first `tick` comes exactly `DIV` cycles later.

## Timing
- Pin-to-effect latency for `enable`, `up_down` and `clear`: the new value acts at the 3rd rising edge after the pin changes. The change is sampled at edge 1 and appears as `_s` after edge 2.
- `tick`:
  - High during the cycle after `p == DIV-1`.
  - The first `tick` is high in cycle `DIV` after reset release, counting the first edge as cycle 1.
  - Period is exactly `DIV` cycles.
- `count` changes at the rising edge that ends a `tick`-high cycle, when `enable_s` is high. `wrap` is high for exactly that following cycle.
- `load`:
  - One-cycle latency.
  - A `load` that coincides with a tick suppresses that step.
  - `count` equals `load_value` on the next cycle.
- `clear` with `load` active: `clear` wins.
- `at_zero` and `at_max` are valid in the same cycle as `count`.

## Configuration
- `TICK_COUNTER_SATURATE_EN`:
  - Defined: stepping up at `2^WIDTH-1` or down at 0 holds the count, and `wrap` stays 0. The port still exists and is tied low.
  - Undefined: wrap-around behaviour as described in Operation.
- Load and clear behave identically in both builds.

## Test plan
- Reset and tick period (`CLK_HZ=8`, `TICK_HZ=1`, `WIDTH=4`): release `reset_n` -> `tick` pulses in cycles 8, 16, 24; `count` stays 0 while `enable` = 0.
- Up-count with wrap: `enable=1`, `up_down=1` for 16 ticks -> `count` goes 1..15 then 0; `wrap` is one cycle high at the 15->0 step only; `at_max` is high while `count = 15`.
- Down-count with wrap: `up_down=0` from 0 -> `count = 15` with `wrap` pulse. With `TICK_COUNTER_SATURATE_EN`: `count` holds 0 and `wrap = 0`.
- Load/clear priority:
  - `load_value=9` with `load` pulsed -> `count = 9` next cycle.
  - `load` coincident with a tick -> `count = 9`, with no step.
  - `clear` and `load` together -> `count = 0`, `p = 0`, next `tick` `DIV` cycles later.
- Synchroniser latency: toggle the `enable` pin 2 cycles before a tick -> that tick is ignored. Toggle it 3 or more cycles before -> that tick steps the count.
- Async reset mid-count: assert `reset_n=0` at `count = 7` in mid-prescale -> `count`, `tick` and `wrap` go to 0 immediately, without waiting for a clock edge.
